// File: rtl/exec_int_sequencer.sv
// exec_int_sequencer: execute-stage interrupt entry / RTI stack sequencer; optional pending queue via EXEC_INT_PEND_EN
module exec_int_sequencer #(
  parameter logic [31:0] VEC1 = 32'h0000_0002,
  parameter logic [31:0] VEC2 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int1_ex,
  input  logic        int2_ex,
  input  logic        rti_ex,
  input  logic [31:0] ret_pc,
  input  logic [2:0]  flags_ex,
  input  logic [31:0] sp,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        flush,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        sp_wr,
  output logic [31:0] sp_next,
  output logic        pc_wr,
  output logic [31:0] pc_val,
  output logic        flags_wr,
  output logic [2:0]  flags_val
);
  typedef enum logic [3:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG, VECTOR, POP_FLG, POP_PCL, POP_PCH, RESUME} state_t;
  state_t state, state_nx;
  logic [31:0] spc, rpc, vec;
  logic [2:0] flg;
  logic [1:0] pend;
  logic first, take, sel1, push, pop;
  assign take = int1_ex | int2_ex | (|pend);
  assign sel1 = int1_ex | (~int2_ex & pend[0]);
`ifdef EXEC_INT_PEND_EN
  // losers of a coincidence and anything arriving mid-sequence wait here
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else pend <= state != IDLE ? pend | {int2_ex, int1_ex}
               : (int1_ex | int2_ex) ? pend | {int1_ex & int2_ex, 1'b0}
               : pend[0] ? {pend[1], 1'b0} : 2'b00;
`else
  assign pend = 2'b00;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = take ? PUSH_PCH : rti_ex ? POP_FLG : IDLE;
      PUSH_PCH: state_nx = mem_ack ? PUSH_PCL : PUSH_PCH;
      PUSH_PCL: state_nx = mem_ack ? PUSH_FLG : PUSH_PCL;
      PUSH_FLG: state_nx = mem_ack ? VECTOR : PUSH_FLG;
      POP_FLG:  state_nx = mem_ack ? POP_PCL : POP_FLG;
      POP_PCL:  state_nx = mem_ack ? POP_PCH : POP_PCL;
      POP_PCH:  state_nx = mem_ack ? RESUME : POP_PCH;
      default:  state_nx = IDLE;
    endcase
  end
  assign push      = state inside {PUSH_PCH, PUSH_PCL, PUSH_FLG};
  assign pop       = state inside {POP_FLG, POP_PCL, POP_PCH};
  assign busy      = state != IDLE;
  assign flush     = first;
  assign mem_wr    = push;
  assign mem_rd    = pop;
  assign mem_addr  = push ? spc : pop ? spc + 32'd1 : '0;
  assign mem_wdata = state == PUSH_PCH ? rpc[31:16] : state == PUSH_PCL ? rpc[15:0]
                   : state == PUSH_FLG ? {13'b0, flg} : '0;
  assign sp_wr     = (push | pop) & mem_ack;
  assign sp_next   = !sp_wr ? '0 : push ? spc - 32'd1 : spc + 32'd1;
  assign pc_wr     = state == VECTOR || state == RESUME;
  assign pc_val    = state == VECTOR ? vec : state == RESUME ? rpc : '0;
  assign flags_wr  = state == RESUME;
  assign flags_val = state == RESUME ? flg : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      first <= 1'b0;
      spc   <= '0;
      rpc   <= '0;
      vec   <= '0;
      flg   <= '0;
    end else begin
      state <= state_nx;
      first <= state == IDLE && (take || rti_ex);
      if (state == IDLE) begin
        spc <= sp;
        if (take) begin
          rpc <= ret_pc;
          flg <= flags_ex;
          vec <= sel1 ? VEC1 : VEC2;
        end
      end else if (sp_wr) spc <= sp_next;
      if (state == POP_FLG && mem_ack) flg <= mem_rdata[2:0];
      if (state == POP_PCL && mem_ack) rpc[15:0] <= mem_rdata;
      if (state == POP_PCH && mem_ack) rpc[31:16] <= mem_rdata;
    end
endmodule
